// File: rtl/sevenseg_pkg.sv
// Shared constants, state type and anode helper for the 8-digit seven-segment scanner.
package sevenseg_pkg;

  localparam int NDIG  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {IDLE, BLANK, ON} scan_state_t;

  // Active-low anode pattern with only digit s lit.
  function automatic logic [NDIG-1:0] onehot_n(input logic [SEL_W-1:0] s);
    logic [NDIG-1:0] r;
    r    = '1;
    r[s] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/next_digit_find.sv
// Finds the next enabled digit after cur_sel (circularly) and flags a scan wrap.
module next_digit_find
  import sevenseg_pkg::*;
(
  input  logic [NDIG-1:0]  dig_en,
  input  logic [SEL_W-1:0] cur_sel,
  output logic [SEL_W-1:0] nxt_sel,
  output logic             wrap
);

  logic [SEL_W-1:0] cand [NDIG-1];
  logic [NDIG-2:0]  hit;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG - 1; gi++) begin : g_cand
      assign cand[gi] = cur_sel + SEL_W'(gi + 1);
      assign hit[gi]  = dig_en[cand[gi]];
    end
  endgenerate

  // Walk from the farthest candidate back so the nearest enabled digit wins.
  always_comb begin
    nxt_sel = cur_sel;
    for (int k = NDIG - 2; k >= 0; k--) begin
      if (hit[k]) nxt_sel = cand[k];
    end
    wrap = (nxt_sel <= cur_sel);
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed 8-digit scan controller: blanking between digits, skips
// disabled digits, one-cycle frame pulse on every scan wrap.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NDIG-1:0]  dig_en,
  output logic [SEL_W-1:0] sel,
  output logic [NDIG-1:0]  an_n,
  output logic             frame
);

  localparam int MAX_CYC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(DIV - 1);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] search_from;
  logic [SEL_W-1:0] nxt_sel;
  logic             wrap;

  // Searching from the top digit yields the lowest enabled digit when starting a scan.
  assign search_from = (state == IDLE) ? SEL_W'(NDIG - 1) : sel;

  next_digit_find u_find (
    .dig_en  (dig_en),
    .cur_sel (search_from),
    .nxt_sel (nxt_sel),
    .wrap    (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      an_n  <= '1;
      frame <= 1'b0;
      cnt   <= '0;
    end else begin
      frame <= 1'b0;
      if (!en || dig_en == '0) begin
        state <= IDLE;
        an_n  <= '1;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= BLANK;
            sel   <= nxt_sel;
            an_n  <= '1;
            cnt   <= '0;
          end
          BLANK: begin
            an_n <= '1;
            if (!dig_en[sel]) begin
              // Target vanished before being lit: pick the next one and restart blanking.
              sel <= nxt_sel;
              cnt <= '0;
            end else if (cnt == BLANK_LAST) begin
              state <= ON;
              an_n  <= onehot_n(sel);
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ON: begin
            if (!dig_en[sel] || cnt == ON_LAST) begin
              state <= BLANK;
              sel   <= nxt_sel;
              an_n  <= '1;
              frame <= wrap;
              cnt   <= '0;
            end else begin
              an_n <= onehot_n(sel);
              cnt  <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            an_n  <= '1;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan (DIV=4, BLANK_CYC=2): directed scenarios plus
// randomized en/dig_en traffic against a countdown-based reference model.
module tb_sevenseg_scan;

  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] dig_en;
  logic [2:0] sel;
  logic [7:0] an_n;
  logic       frame;

  int errors = 0;
  int checks = 0;

  // Reference model state: scanning?, digit lit?, digit, cycles left in phase.
  bit m_on, m_lit, m_frame;
  int m_dig, m_left;

  sevenseg_scan #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .dig_en (dig_en),
    .sel    (sel),
    .an_n   (an_n),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ($onehot0(~an_n)) else begin
        errors++;
        $error("FAIL onehot0: observed an_n=%h required at most one low bit", an_n);
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_dig(input int d, input logic [7:0] m);
    for (int k = 1; k < 8; k++) if (m[(d + k) % 8]) return (d + k) % 8;
    return d;
  endfunction

  task automatic model_reset();
    m_on = 0; m_lit = 0; m_frame = 0; m_dig = 0; m_left = 0;
  endtask

  task automatic model_update();
    int nd;
    m_frame = 0;
    if (!en || dig_en == 8'h00) begin
      m_on = 0; m_lit = 0;
    end else if (!m_on) begin
      m_on = 1; m_lit = 0; m_dig = lowest(dig_en); m_left = BLANK_CYC;
    end else if (!m_lit) begin
      if (!dig_en[m_dig]) begin
        m_dig = next_dig(m_dig, dig_en); m_left = BLANK_CYC;
      end else if (m_left == 1) begin
        m_lit = 1; m_left = DIV;
      end else begin
        m_left--;
      end
    end else begin
      if (!dig_en[m_dig] || m_left == 1) begin
        nd = next_dig(m_dig, dig_en);
        m_frame = (nd <= m_dig);
        m_dig = nd; m_lit = 0; m_left = BLANK_CYC;
      end else begin
        m_left--;
      end
    end
  endtask

  task automatic step();
    logic [7:0] exp_an;
    model_update();
    @(posedge clk);
    #1;
    exp_an = m_lit ? (8'hFF ^ (8'd1 << m_dig)) : 8'hFF;
    chk("model_sel", 8'(sel), 8'(m_dig));
    chk("model_an_n", an_n, exp_an);
    chk("model_frame", 8'(frame), 8'(m_frame));
  endtask

  task automatic wait_an(input logic [7:0] target, input string tag);
    int n = 0;
    while (an_n !== target && n < 200) begin
      step();
      n++;
    end
    chk(tag, an_n, target);
  endtask

  task automatic frame_period(input int n_steps, input int expected, input string tag);
    int first = -1;
    int second = -1;
    for (int i = 0; i < n_steps; i++) begin
      step();
      if (frame === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk(tag, 8'(second - first), 8'(expected));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dig_en = 8'hFF;
    model_reset();
    #3;
    chk("reset_sel", 8'(sel), 8'h00);
    chk("reset_an_n", an_n, 8'hFF);
    chk("reset_frame", 8'(frame), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // All digits: blank 2, digit 0 lit from cycle 3, digit 1 lit from cycle 9.
    for (int i = 0; i < 3; i++) step();
    chk("first_on_an_n", an_n, 8'hFE);
    for (int i = 0; i < 6; i++) step();
    chk("digit1_sel", 8'(sel), 8'h01);
    chk("digit1_an_n", an_n, 8'hFD);
    frame_period(110, 48, "frame_period_ff");

    dig_en = 8'b1000_0100;
    frame_period(40, 12, "frame_period_two");

    dig_en = 8'b0001_0000;
    frame_period(20, 6, "frame_period_single");
    wait_an(8'hEF, "single_lit");
    chk("single_sel", 8'(sel), 8'h04);

    // en dropped in the second ON cycle of digit 3, then restarted.
    dig_en = 8'hFF;
    wait_an(8'hF7, "reach_digit3");
    step();
    en = 1'b0;
    step();
    chk("en_drop_an_n", an_n, 8'hFF);
    chk("en_drop_sel", 8'(sel), 8'h03);
    en = 1'b1;
    step();
    chk("restart_sel", 8'(sel), 8'h00);

    // Digit 5 disabled while lit: immediate move to blanking on digit 6.
    wait_an(8'hDF, "reach_digit5");
    dig_en = 8'hDF;
    step();
    chk("skip_sel", 8'(sel), 8'h06);
    chk("skip_an_n", an_n, 8'hFF);

    // Asynchronous reset in the middle of a blank interval.
    dig_en = 8'hFF;
    wait_an(8'hFE, "reach_digit0");
    for (int i = 0; i < 5; i++) step();
    chk("in_blank_an_n", an_n, 8'hFF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", 8'(sel), 8'h00);
    chk("async_rst_an_n", an_n, 8'hFF);
    chk("async_rst_frame", 8'(frame), 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized mask/enable traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 31));
      if (!en && r < 8) en = 1'b1;
      else if (r == 0) en = ~en;
      else if (r <= 2) dig_en = 8'($urandom);
      else if (r == 3) dig_en = 8'd1 << $urandom_range(0, 7);
      else if (r == 4) dig_en[$urandom_range(0, 7)] = ~dig_en[$urandom_range(0, 7)];
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
